// File: rtl/am9513_ctx_bank.sv
// am9513_ctx_bank: per-context FPU state bank (rounding mode, sticky flags, regfile, legacy stack)
// with a SAVE/LOAD/CLEAR context transfer engine for OS spill and fill.
module am9513_ctx_bank #(
    parameter int NUM_CONTEXTS = 64,
    parameter int NUM_REGS     = 16,
    parameter int DATA_W       = 64,
    parameter int STACK_DEPTH  = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [15:0]                        ctx_sel,
    input  logic [$clog2(NUM_REGS)-1:0]        rd_idx_a,
    input  logic [$clog2(NUM_REGS)-1:0]        rd_idx_b,
    output logic [DATA_W-1:0]                  rd_data_a,
    output logic [DATA_W-1:0]                  rd_data_b,
    output logic [1:0]                         rm_rdata,
    output logic [4:0]                         flags_rdata,
    input  logic                               rm_we,
    input  logic [1:0]                         rm_wdata,
    input  logic                               flags_or_we,
    input  logic [4:0]                         flags_or_mask,
    input  logic                               flags_clr_we,
    input  logic [4:0]                         flags_clr_mask,
    input  logic                               rf_we,
    input  logic [$clog2(NUM_REGS)-1:0]        rf_widx,
    input  logic [DATA_W-1:0]                  rf_wdata,
    input  logic                               stk_push,
    input  logic                               stk_pop,
    input  logic [DATA_W-1:0]                  stk_wdata,
    output logic [DATA_W-1:0]                  stk_top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stk_depth,
    output logic                               stk_empty,
    output logic                               stk_full,
    output logic                               stk_ovf_pulse,
    output logic                               stk_unf_pulse,
    input  logic                               xfer_cmd_valid,
    output logic                               xfer_cmd_ready,
    input  logic [1:0]                         xfer_cmd_op,
    input  logic [15:0]                        xfer_ctx,
    output logic                               save_valid,
    input  logic                               save_ready,
    output logic [DATA_W-1:0]                  save_data,
    input  logic                               load_valid,
    output logic                               load_ready,
    input  logic [DATA_W-1:0]                  load_data,
    output logic                               xfer_busy,
    output logic                               xfer_done_pulse,
    output logic                               xfer_err_pulse
);
    localparam int RI_W  = $clog2(NUM_REGS);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int SI_W  = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    localparam int CI_W  = NUM_CONTEXTS > 1 ? $clog2(NUM_CONTEXTS) : 1;
    localparam int N     = 1 + NUM_REGS + STACK_DEPTH;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [15:0]      NC16     = 16'(NUM_CONTEXTS);
    localparam logic [SP_W-1:0]  SP_MAX   = SP_W'(STACK_DEPTH);
    localparam logic [CNT_W-1:0] CNT_REGS = CNT_W'(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_STK  = CNT_W'(NUM_REGS + 1);

    typedef enum logic [1:0] {S_IDLE, S_SAVE, S_LOAD, S_CLEAR} state_t;

    logic [1:0]        rm_q    [NUM_CONTEXTS];
    logic [4:0]        flags_q [NUM_CONTEXTS];
    logic [SP_W-1:0]   sp_q    [NUM_CONTEXTS];
    logic [DATA_W-1:0] regs_q  [NUM_CONTEXTS][NUM_REGS];
    logic [DATA_W-1:0] stk_q   [NUM_CONTEXTS][STACK_DEPTH];

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CI_W-1:0]  tctx_q;
    logic             sat_q, done_q, err_q, ovf_q, unf_q;

    logic             sel_ok, xctx_ok, arch_ok, flags_wr, stk_wr, ovf_d, unf_d;
    logic             ld_beat, hdr_sat, last;
    logic [CI_W-1:0]  ci;
    logic [SP_W-1:0]  cur_sp, sp_nxt, hdr_sp;
    logic [SI_W-1:0]  stk_widx, sidx;
    logic [RI_W-1:0]  ridx;
    logic [4:0]       flags_nxt;

    always_comb begin
        sel_ok      = ctx_sel < NC16;
        xctx_ok     = xfer_ctx < NC16;
        ci          = ctx_sel[CI_W-1:0];
        cur_sp      = sp_q[ci];
        arch_ok     = sel_ok && state_q == S_IDLE;
        rd_data_a   = sel_ok ? regs_q[ci][rd_idx_a] : '0;
        rd_data_b   = sel_ok ? regs_q[ci][rd_idx_b] : '0;
        rm_rdata    = sel_ok ? rm_q[ci] : 2'd0;
        flags_rdata = sel_ok ? flags_q[ci] : 5'd0;
        stk_depth   = sel_ok ? cur_sp : '0;
        stk_empty   = !sel_ok || cur_sp == '0;
        stk_full    = sel_ok && cur_sp == SP_MAX;
        stk_top     = stk_empty ? '0 : stk_q[ci][SI_W'(cur_sp - 1'b1)];
        flags_nxt   = (flags_q[ci] & ~(flags_clr_we ? flags_clr_mask : 5'd0)) |
                      (flags_or_we ? flags_or_mask : 5'd0);
        flags_wr    = flags_or_we || flags_clr_we;
        // push+pop on a non-empty stack overwrites the top; on an empty one it is a plain push
        ovf_d       = arch_ok && stk_push && !stk_pop && stk_full;
        unf_d       = arch_ok && stk_pop && !stk_push && stk_empty;
        stk_wr      = stk_push && (stk_pop || !stk_full);
        stk_widx    = SI_W'(stk_pop && !stk_empty ? cur_sp - 1'b1 : cur_sp);
        sp_nxt      = stk_push && (stk_pop ? stk_empty : !stk_full) ? cur_sp + 1'b1 :
                      stk_pop && !stk_push && !stk_empty ? cur_sp - 1'b1 : cur_sp;
        ridx        = RI_W'(cnt_q - 1'b1);
        sidx        = SI_W'(cnt_q - CNT_STK);
        last        = cnt_q == CNT_LAST;
        hdr_sp      = load_data[7 +: SP_W];
        hdr_sat     = hdr_sp > SP_MAX;
        ld_beat     = state_q == S_LOAD && load_valid;
        save_data   = cnt_q == '0 ? DATA_W'({sp_q[tctx_q], flags_q[tctx_q], rm_q[tctx_q]}) :
                      cnt_q <= CNT_REGS ? regs_q[tctx_q][ridx] : stk_q[tctx_q][sidx];
    end

    assign xfer_cmd_ready  = state_q == S_IDLE;
    assign xfer_busy       = state_q != S_IDLE;
    assign save_valid      = state_q == S_SAVE;
    assign load_ready      = state_q == S_LOAD;
    assign xfer_done_pulse = done_q;
    assign xfer_err_pulse  = err_q;
    assign stk_ovf_pulse   = ovf_q;
    assign stk_unf_pulse   = unf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CONTEXTS; c++) begin
                rm_q[c]    <= 2'd0;
                flags_q[c] <= 5'd0;
                sp_q[c]    <= '0;
                for (int r = 0; r < NUM_REGS; r++) regs_q[c][r] <= '0;
                for (int s = 0; s < STACK_DEPTH; s++) stk_q[c][s] <= '0;
            end
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (arch_ok) begin
                if (rm_we) rm_q[ci] <= rm_wdata;
                if (flags_wr) flags_q[ci] <= flags_nxt;
                if (rf_we) regs_q[ci][rf_widx] <= rf_wdata;
                if (stk_wr) stk_q[ci][stk_widx] <= stk_wdata;
                sp_q[ci] <= sp_nxt;
            end
            if (ld_beat) begin
                if (cnt_q == '0) begin
                    rm_q[tctx_q]    <= load_data[1:0];
                    flags_q[tctx_q] <= load_data[6:2];
                    sp_q[tctx_q]    <= hdr_sat ? SP_MAX : hdr_sp;
                end else if (cnt_q <= CNT_REGS) begin
                    regs_q[tctx_q][ridx] <= load_data;
                end else begin
                    stk_q[tctx_q][sidx] <= load_data;
                end
            end
            if (state_q == S_CLEAR) begin
                rm_q[tctx_q]    <= 2'd0;
                flags_q[tctx_q] <= 5'd0;
                sp_q[tctx_q]    <= '0;
                for (int r = 0; r < NUM_REGS; r++) regs_q[tctx_q][r] <= '0;
                for (int s = 0; s < STACK_DEPTH; s++) stk_q[tctx_q][s] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tctx_q  <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: if (xfer_cmd_valid) begin
                    if (!xctx_ok || xfer_cmd_op == 2'd3) begin
                        err_q <= 1'b1;
                    end else begin
                        state_q <= state_t'(xfer_cmd_op + 2'd1);
                        cnt_q   <= '0;
                        tctx_q  <= xfer_ctx[CI_W-1:0];
                        sat_q   <= 1'b0;
                    end
                end
                S_SAVE: if (save_ready) begin
                    if (last) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_LOAD: if (load_valid) begin
                    if (cnt_q == '0 && hdr_sat) sat_q <= 1'b1;
                    if (last) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                        err_q   <= sat_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_am9513_ctx_bank.sv
// tb_am9513_ctx_bank: directed bench for the context bank; transfer streams checked via a scoreboard queue.
module tb_am9513_ctx_bank;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ctx_sel, xfer_ctx;
    logic [3:0]  rd_idx_a, rd_idx_b, rf_widx;
    logic [63:0] rd_data_a, rd_data_b, rf_wdata, stk_wdata, stk_top, save_data, load_data;
    logic [1:0]  rm_rdata, rm_wdata, xfer_cmd_op;
    logic [4:0]  flags_rdata, flags_or_mask, flags_clr_mask, stk_depth;
    logic        rm_we, flags_or_we, flags_clr_we, rf_we, stk_push, stk_pop;
    logic        stk_empty, stk_full, stk_ovf_pulse, stk_unf_pulse;
    logic        xfer_cmd_valid, xfer_cmd_ready, save_valid, save_ready, load_valid, load_ready;
    logic        xfer_busy, xfer_done_pulse, xfer_err_pulse;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    logic [63:0] frame[33];

    am9513_ctx_bank dut (
        .clk(clk), .rst_n(rst_n), .ctx_sel(ctx_sel), .rd_idx_a(rd_idx_a), .rd_idx_b(rd_idx_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rm_rdata(rm_rdata), .flags_rdata(flags_rdata),
        .rm_we(rm_we), .rm_wdata(rm_wdata), .flags_or_we(flags_or_we), .flags_or_mask(flags_or_mask),
        .flags_clr_we(flags_clr_we), .flags_clr_mask(flags_clr_mask), .rf_we(rf_we), .rf_widx(rf_widx),
        .rf_wdata(rf_wdata), .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
        .stk_top(stk_top), .stk_depth(stk_depth), .stk_empty(stk_empty), .stk_full(stk_full),
        .stk_ovf_pulse(stk_ovf_pulse), .stk_unf_pulse(stk_unf_pulse), .xfer_cmd_valid(xfer_cmd_valid),
        .xfer_cmd_ready(xfer_cmd_ready), .xfer_cmd_op(xfer_cmd_op), .xfer_ctx(xfer_ctx),
        .save_valid(save_valid), .save_ready(save_ready), .save_data(save_data),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .xfer_busy(xfer_busy), .xfer_done_pulse(xfer_done_pulse), .xfer_err_pulse(xfer_err_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [15:0] ctx);
        xfer_cmd_op = op;
        xfer_ctx = ctx;
        xfer_cmd_valid = 1'b1;
        tick;
        xfer_cmd_valid = 1'b0;
    endtask

    initial begin
        int beats, idx;
        logic got_done, got_err, acc, ovf_seen;
        rst_n = 1'b0;
        ctx_sel = '0; xfer_ctx = '0; rd_idx_a = '0; rd_idx_b = '0; rf_widx = '0;
        rf_wdata = '0; stk_wdata = '0; load_data = '0; rm_wdata = '0; xfer_cmd_op = '0;
        flags_or_mask = '0; flags_clr_mask = '0; rm_we = 0; flags_or_we = 0; flags_clr_we = 0;
        rf_we = 0; stk_push = 0; stk_pop = 0; xfer_cmd_valid = 0; save_ready = 0; load_valid = 0;
        tick;
        tick;
        chk("rst_cmd_ready", xfer_cmd_ready, 1);
        chk("rst_busy", xfer_busy, 0);
        chk("rst_save_valid", save_valid, 0);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_empty", stk_empty, 1);
        rst_n = 1'b1;
        tick;

        ctx_sel = 3; rf_we = 1; rf_widx = 5; rf_wdata = 64'hDEAD; rd_idx_a = 5;
        #1 chk("no_read_through", rd_data_a, 0);
        tick;
        rf_we = 0;
        chk("rf_write_ctx3", rd_data_a, 64'hDEAD);
        ctx_sel = 4;
        #1 chk("rf_ctx4_isolated", rd_data_a, 0);

        ctx_sel = 3; flags_or_we = 1; flags_or_mask = 5'b00011;
        tick;
        chk("flags_or", flags_rdata, 5'b00011);
        flags_or_mask = 5'b00100; flags_clr_we = 1; flags_clr_mask = 5'b00001;
        tick;
        flags_or_we = 0; flags_clr_we = 0;
        chk("flags_clr_or", flags_rdata, 5'b00110);

        ctx_sel = 0; stk_push = 1;
        for (int i = 0; i < 16; i++) begin
            stk_wdata = 64'h100 + 64'(i);
            tick;
        end
        chk("stk_full", stk_full, 1);
        chk("stk_depth16", stk_depth, 16);
        chk("stk_top115", stk_top, 64'h10F);
        stk_wdata = 64'h999;
        tick;
        stk_push = 0;
        chk("ovf_pulse", stk_ovf_pulse, 1);
        chk("ovf_top_kept", stk_top, 64'h10F);
        tick;
        chk("ovf_one_cycle", stk_ovf_pulse, 0);
        stk_push = 1; stk_pop = 1; stk_wdata = 64'hBEEF;
        tick;
        stk_push = 0; stk_pop = 0;
        chk("replace_top", stk_top, 64'hBEEF);
        chk("replace_depth", stk_depth, 16);
        ctx_sel = 1; stk_pop = 1;
        tick;
        stk_pop = 0;
        chk("unf_pulse", stk_unf_pulse, 1);
        chk("unf_depth", stk_depth, 0);
        ctx_sel = 100;
        #1 chk("inv_empty", stk_empty, 1);
        chk("inv_rd", rd_data_a, 0);

        ctx_sel = 2; rm_we = 1; rm_wdata = 2; flags_or_we = 1; flags_or_mask = 5'b00001;
        stk_push = 1; stk_wdata = 64'h55; rf_we = 1; rf_widx = 0; rf_wdata = 7;
        tick;
        rm_we = 0; flags_or_we = 0; stk_push = 0; rf_we = 0;
        sb.push_back(64'h86);
        sb.push_back(64'h7);
        for (int i = 1; i < 16; i++) sb.push_back(0);
        sb.push_back(64'h55);
        for (int i = 1; i < 16; i++) sb.push_back(0);
        cmd(2'd0, 16'd2);
        chk("save_busy", xfer_busy, 1);
        beats = 0; got_done = 0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            save_ready = c[0];
            if (save_valid && save_ready) begin
                chk($sformatf("save_beat%0d", beats), save_data, sb.size() > 0 ? sb.pop_front() : 64'hX);
                beats++;
            end
            tick;
            got_done = xfer_done_pulse;
        end
        save_ready = 0;
        chk("save_beats", beats, 33);
        chk("save_done", got_done, 1);
        chk("save_sb_empty", sb.size(), 0);
        chk("save_idle", xfer_busy, 0);

        frame[0] = 64'hFD7;
        for (int i = 0; i < 16; i++) frame[1+i] = 64'h1000 + 64'(i);
        for (int i = 0; i < 16; i++) frame[17+i] = 64'h2000 + 64'(i);
        cmd(2'd1, 16'd9);
        chk("load_ready", load_ready, 1);
        ctx_sel = 5; stk_push = 1; stk_wdata = 64'hAA;
        idx = 0; got_done = 0; got_err = 0; ovf_seen = 0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            load_valid = (c % 3) != 1;
            load_data = idx < 33 ? frame[idx] : 64'h0;
            acc = load_valid && load_ready;
            tick;
            if (acc) idx++;
            ovf_seen |= stk_ovf_pulse;
            got_done = xfer_done_pulse;
            got_err = xfer_err_pulse;
        end
        load_valid = 0; stk_push = 0;
        chk("load_beats", idx, 33);
        chk("load_done", got_done, 1);
        chk("load_err_sat", got_err, 1);
        chk("busy_push_ignored", stk_depth, 0);
        chk("busy_no_ovf", ovf_seen, 0);
        ctx_sel = 9; rd_idx_a = 4; rd_idx_b = 15;
        sb.push_back(16); sb.push_back(3); sb.push_back(5'h15);
        sb.push_back(64'h1004); sb.push_back(64'h100F); sb.push_back(64'h200F);
        #1;
        chk("load_sp_sat", stk_depth, sb.pop_front());
        chk("load_rm", rm_rdata, sb.pop_front());
        chk("load_flags", flags_rdata, sb.pop_front());
        chk("load_reg4", rd_data_a, sb.pop_front());
        chk("load_reg15", rd_data_b, sb.pop_front());
        chk("load_top", stk_top, sb.pop_front());

        cmd(2'd0, 16'd64);
        chk("bad_ctx_err", xfer_err_pulse, 1);
        chk("bad_ctx_ready", xfer_cmd_ready, 1);
        chk("bad_ctx_busy", xfer_busy, 0);
        cmd(2'd3, 16'd1);
        chk("rsvd_op_err", xfer_err_pulse, 1);
        chk("rsvd_op_done", xfer_done_pulse, 0);

        cmd(2'd2, 16'd9);
        chk("clear_busy", xfer_busy, 1);
        tick;
        chk("clear_done", xfer_done_pulse, 1);
        chk("clear_depth", stk_depth, 0);
        chk("clear_reg4", rd_data_a, 0);
        chk("clear_rm", rm_rdata, 0);

        cmd(2'd0, 16'd2);
        chk("save2_valid", save_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", save_valid, 0);
        chk("rst_mid_busy", xfer_busy, 0);
        chk("rst_mid_ready", xfer_cmd_ready, 1);
        ctx_sel = 3; rd_idx_a = 5;
        #1 chk("rst_wipes_reg", rd_data_a, 0);
        tick;
        rst_n = 1'b1;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
